// File: rtl/fp_defs.sv
// ============================================================================
// Module   : fp_defs
// Brief    : Shared FP word type, constants and reduction-controller states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp_defs;

    localparam int C_OP = 16;

    typedef logic [C_OP-1:0] fp_t;

    localparam fp_t FP_POS_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } acc_state_e;

endpackage : fp_defs

`default_nettype wire

// File: rtl/fp_acc_sequencer.sv
// ============================================================================
// Module   : fp_acc_sequencer
// Brief    : Drives a 1-cycle fp_adder as a left-fold reduction over a vector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_acc_sequencer
    import fp_defs::*;
#(
    parameter int C_OP    = fp_defs::C_OP,
    parameter int C_LEN_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [C_LEN_W-1:0] len_i,
    output logic               busy_o,
    input  logic               in_valid_i,
    input  logic [C_OP-1:0]    in_data_i,
    output logic               in_ready_o,
    output logic [C_OP-1:0]    add_op_a_o,
    output logic [C_OP-1:0]    add_op_b_o,
    input  logic [C_OP-1:0]    add_result_i,
    output logic               out_valid_o,
    output logic [C_OP-1:0]    out_data_o,
    input  logic               out_ready_i
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_ISSUE   = ISSUE;
    localparam logic [1:0] ST_CAPTURE = CAPTURE;
    localparam logic [1:0] ST_DONE    = DONE;

    logic [1:0]         state_q, state_d;
    logic [C_OP-1:0]    acc_q, acc_d;
    logic [C_LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d   = C_OP'(FP_POS_ZERO);
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (in_valid_i) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The adder result for the operands issued last cycle is valid now.
                acc_d   = add_result_i;
                cnt_d   = cnt_q - C_LEN_W'(1);
                state_d = (cnt_q == C_LEN_W'(1)) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign in_ready_o  = (state_q == ST_ISSUE);
    assign add_op_a_o  = (state_q == ST_ISSUE) ? acc_q : '0;
    assign add_op_b_o  = (state_q == ST_ISSUE) ? in_data_i : '0;
    assign out_valid_o = (state_q == ST_DONE);
    assign out_data_o  = (state_q == ST_DONE) ? acc_q : '0;

endmodule : fp_acc_sequencer

`default_nettype wire

// File: tb/tb_fp_acc_sequencer.sv
// ============================================================================
// Module   : tb_fp_acc_sequencer
// Brief    : Sequencer bench with a behavioural 1-cycle fp16 adder attached.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_acc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic [15:0] add_res;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_acc_sequencer #(.C_OP(16), .C_LEN_W(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .len_i        (len),
        .busy_o       (busy),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .add_op_a_o   (op_a),
        .add_op_b_o   (op_b),
        .add_result_i (add_res),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready)
    );

    // Truncating fp16 add: denormals flush to zero, exact cancellation gives +0.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [14:0] mx, my, m;
        int          ex, ey, e, d;
        logic        s;
        if (a[14:10] == 5'd0) return (b[14:10] == 5'd0) ? 16'h0000 : b;
        if (b[14:10] == 5'd0) return a;
        if (a[14:10] == 5'd31) return a;
        if (b[14:10] == 5'd31) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = int'(x[14:10]);
        ey = int'(y[14:10]);
        d  = ex - ey;
        mx = {2'b01, x[9:0], 3'b000};
        my = {2'b01, y[9:0], 3'b000};
        my = (d > 13) ? 15'd0 : (my >> d);
        s  = x[15];
        m  = (x[15] == y[15]) ? (mx + my) : (mx - my);
        e  = ex;
        if (m == 15'd0) return 16'h0000;
        if (m[14]) begin m = m >> 1; e = e + 1; end
        while (!m[13]) begin m = m << 1; e = e - 1; end
        if (e <= 0) return {s, 15'h0000};
        if (e >= 31) return {s, 5'h1f, 10'h000};
        return {s, e[4:0], m[12:3]};
    endfunction

    logic [15:0] add_a_q, add_b_q;
    always @(posedge clk) begin
        if (rst) begin
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            add_a_q <= op_a;
            add_b_q <= op_b;
        end
    end
    always_comb add_res = fp16_add(add_a_q, add_b_q);

    logic [15:0] vec_q[$];
    int          rdy_hist[8];
    int          hs_cnt, last_hs_cyc, out_cyc;
    logic [15:0] run_res;
    logic        run_timeout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one reduction over vec_q, recording observations only.
    task automatic run_vec(input int vpct, input int rpct, input bit extra_valid,
                           input int gap_at, input int gap_cycles);
        int k = 0, cyc = 0, gap_cnt = 0;
        bit seen = 0;
        hs_cnt = 0; last_hs_cyc = -1; out_cyc = -1; run_res = '0; run_timeout = 0;
        for (int i = 0; i < 8; i++) rdy_hist[i] = -1;
        start = 1'b1;
        len   = 16'(vec_q.size());
        tick();
        start = 1'b0;
        forever begin
            if (k < vec_q.size()) begin
                in_data  = vec_q[k];
                in_valid = ($urandom_range(99) < vpct);
                if (k == gap_at && gap_cnt < gap_cycles) begin
                    in_valid = 1'b0;
                    gap_cnt++;
                end
            end else begin
                in_data  = 16'h3C00;
                in_valid = extra_valid;
            end
            out_ready = ($urandom_range(99) < rpct);
            #1;
            if (cyc < 8) rdy_hist[cyc] = int'(in_ready);
            if (out_valid && !seen) begin
                seen    = 1;
                out_cyc = cyc;
                run_res = out_data;
            end
            if (in_ready && in_valid) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                k++;
            end
            if (out_valid && out_ready) begin
                tick();
                break;
            end
            if (cyc > 400) begin
                run_timeout = 1;
                break;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks += 6;
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_data !== 16'h0)  begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        if (op_a !== 16'h0)      begin failures++; $display("FAIL reset_op_a got=%h exp=0000", op_a); end
        if (op_b !== 16'h0)      begin failures++; $display("FAIL reset_op_b got=%h exp=0000", op_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 16'h4000;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks += 6;
        if (busy !== 1'b0)      begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        if (out_data !== 16'h0) begin failures++; $display("FAIL midrst_out_data got=%h exp=0000", out_data); end
        if (op_a !== 16'h0)     begin failures++; $display("FAIL midrst_op_a got=%h exp=0000", op_a); end
        if (op_b !== 16'h0)     begin failures++; $display("FAIL midrst_op_b got=%h exp=0000", op_b); end
        tick();
    endtask

    task automatic test_basic();
        int exp_rdy[6] = '{1, 0, 1, 0, 1, 0};
        vec_q = '{16'h3C00, 16'h4000, 16'h3800};
        run_vec(100, 100, 1'b0, -1, 0);
        checks++;
        if (run_timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rdy_hist[i] != exp_rdy[i]) begin
                failures++;
                $display("FAIL basic_in_ready[%0d] got=%0d exp=%0d", i, rdy_hist[i], exp_rdy[i]);
            end
        end
        checks += 3;
        if (run_res !== 16'h4300) begin failures++; $display("FAIL basic_sum got=%h exp=4300", run_res); end
        if (out_cyc - last_hs_cyc != 2) begin
            failures++; $display("FAIL basic_latency got=%0d exp=2", out_cyc - last_hs_cyc);
        end
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%b exp=0", busy); end
    endtask

    task automatic test_len0();
        start = 1'b1; len = 16'd0; in_valid = 1'b1; in_data = 16'h3C00;
        tick();
        start = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL len0_valid got=%b exp=1", out_valid); end
        if (out_data !== 16'h0) begin failures++; $display("FAIL len0_data got=%h exp=0000", out_data); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL len0_in_ready got=%b exp=0", in_ready); end
        if (busy !== 1'b1)      begin failures++; $display("FAIL len0_busy got=%b exp=1", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL len0_idle got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_gap();
        vec_q = '{16'h4200, 16'hC200};
        run_vec(100, 100, 1'b1, 1, 4);
        checks += 3;
        if (run_timeout)        begin failures++; $display("FAIL gap_timeout got=1 exp=0"); end
        if (hs_cnt != 2)        begin failures++; $display("FAIL gap_handshakes got=%0d exp=2", hs_cnt); end
        if (run_res !== 16'h0)  begin failures++; $display("FAIL gap_sum got=%h exp=0000", run_res); end
    endtask

    task automatic test_done_stall();
        logic [15:0] held;
        start = 1'b1; len = 16'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 16'h3C00;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        held = 16'h3C00;
        for (int i = 0; i < 5; i++) begin
            checks += 2;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
            if (out_data !== held)  begin failures++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, out_data, held); end
            start = (i % 2 == 0); len = 16'd5;
            tick();
        end
        start = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0)      begin failures++; $display("FAIL stall_idle got=%b exp=0", busy); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_after got=%b exp=0", out_valid); end
        tick();
        if (busy !== 1'b0)      begin failures++; $display("FAIL stall_start_dropped got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n = (r == 0) ? 16 : int'($urandom_range(8, 1));
            logic [15:0] golden = 16'h0000;
            vec_q = {};
            for (int i = 0; i < n; i++) begin
                logic [15:0] e;
                e = {1'($urandom_range(1)), 5'($urandom_range(18, 12)), 10'($urandom)};
                vec_q.push_back(e);
                golden = fp16_add(golden, e);
            end
            run_vec(60, 50, 1'b1, -1, 0);
            checks += 3;
            if (run_timeout)       begin failures++; $display("FAIL rand%0d_timeout got=1 exp=0", r); end
            if (hs_cnt != n)       begin failures++; $display("FAIL rand%0d_handshakes got=%0d exp=%0d", r, hs_cnt, n); end
            if (run_res !== golden) begin failures++; $display("FAIL rand%0d_sum got=%h exp=%h", r, run_res, golden); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_len0();
        test_gap();
        test_done_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_acc_sequencer

`default_nettype wire

// File: doc/fp_acc_sequencer.md
Name: fp_acc_sequencer

Overview:
- Initiator side of the `fp_adder` operand/result interface. It takes a stream of packed FP words on a valid/ready input and drives `fp_adder`'s two operand ports with {running sum, next element}.
- It captures the adder's result one cycle later and presents the final sum of a programmed-length vector on a valid/ready output.
- It sits between a vector source (e.g. a halut LUT readout) and downstream consumers. It is the sequential controller that turns the stateless adder into a reduction unit.

Parameters:
- C_OP, fp_defs::C_OP (16), packed float width (sign|exp|mant).
- C_LEN_W, 16, width of the vector-length field.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, begin a new reduction; sampled only in IDLE.
- len_i, in, C_LEN_W, number of elements to sum; sampled with start_i.
- busy_o, out, 1, high in any state other than IDLE.
- in_valid_i, in, 1, element available.
- in_data_i, in, C_OP, element (packed float).
- in_ready_o, out, 1, element accepted when in_valid_i && in_ready_o.
- add_op_a_o, out, C_OP, to fp_adder operand_a_di.
- add_op_b_o, out, C_OP, to fp_adder operand_b_di.
- add_result_i, in, C_OP, from fp_adder result_do.
- out_valid_o, out, 1, sum available.
- out_data_o, out, C_OP, final sum.
- out_ready_i, in, 1, consumer accepts sum.

Behaviour:
- Adder contract:
  - fp_adder registers its operands at each rising edge.
  - add_result_i is valid during the cycle after the operands were driven, and is combinational from those registers.
  - Adder latency is exactly 1 cycle; no handshake exists on that interface.
  - The integrator ties fp_adder rst_ni = ~rst_i.
- Reset (synchronous, rst_i=1 at a rising edge):
  - state=IDLE, acc_q=0, cnt_q=0.
  - All outputs 0: busy_o, in_ready_o, out_valid_o, out_data_o, add_op_a_o, add_op_b_o.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - in_ready_o=0.
  - On start_i: acc_q<=+0 (all zeros) and cnt_q<=len_i.
  - If len_i==0, go to DONE (sum = +0); otherwise go to ISSUE.
- ISSUE:
  - in_ready_o=1, add_op_a_o=acc_q, add_op_b_o=in_data_i.
  - On an in_valid_i handshake, go to CAPTURE; otherwise stay, with the operand ports still driven and the adder result ignored.
- CAPTURE:
  - in_ready_o=0.
  - acc_q<=add_result_i and cnt_q<=cnt_q-1.
  - If cnt_q==1, go to DONE; otherwise go to ISSUE.
- DONE:
  - out_valid_o=1, out_data_o=acc_q, held stable until out_ready_i.
  - On out_ready_i, go to IDLE.
- Throughput: 1 element per 2 cycles.
- Latency: the last element handshake in cycle t gives out_valid_o in cycle t+2.
- Operand ports outside ISSUE: both driven to 0.
- start_i outside IDLE: ignored; len_i is not re-sampled.
- in_valid_i outside ISSUE: ignored; no element is consumed.
- out_valid_o with out_ready_i already high: the handshake completes in the first DONE cycle.
- Back-to-back reductions:
  - The IDLE cycle after DONE is mandatory.
  - start_i asserted in the DONE cycle is dropped.
- Reset mid-operation: the partial sum and any in-flight adder result are discarded, and the block returns to IDLE the next cycle.
- cnt_q wrap: impossible, because the decrement occurs only when cnt_q≥1.
- Special values (denormal, inf, NaN) pass through the adder unmodified; this block performs no FP interpretation.

Decomposition:
- fp_defs package:
  - Add typedef fp_t = logic [C_OP-1:0].
  - Add FP_POS_ZERO constant.
  - Add an enum acc_state_e {IDLE, ISSUE, CAPTURE, DONE}.
- No sub-modules inside the block.
- Top-level wrapper fp_acc_unit instantiates fp_acc_sequencer plus fp_adder; it is the DUT for the tests below.

Test Plan:
- Reset held 3 cycles mid-reduction, then released -> all outputs 0, busy_o=0, and a subsequent start works normally.
- start_i, len_i=3, elements 0x3C00 (1.0), 0x4000 (2.0), 0x3800 (0.5), in_valid_i always high -> out_data_o=0x4300 (3.5); out_valid_o 2 cycles after the 3rd handshake; in_ready_o toggles 1,0,1,0,1,0.
- len_i=0 -> DONE the cycle after start; out_data_o=0x0000; in_ready_o never asserted.
- len_i=2, elements 0x4200 (3.0) and 0xC200 (-3.0), with a 4-cycle in_valid_i gap between them -> out_data_o sign=0, exp=0, mant=0; no extra element consumed during the gap.
- out_ready_i low for 5 cycles in DONE -> out_valid_o and out_data_o stable; start_i pulses during DONE ignored; IDLE the cycle after out_ready_i.
- 16 random fp16 normals with random in_valid_i/out_ready_i stalls -> result bit-exact against a sequential golden model using the same adder, left-fold order from +0.
